mem_commit_watchdog: RTL and testbench

Synthesizable run-control and bus-sanity monitor that sits beside the CPU core in the bench top. It replaces the hand-written commit-order counter, halt detector, timeout, error-drain and read/write-collision checks with a single parametrised block. It generalises them to NUM_PORTS memory ports (split I/D or cache ports), adds per-port response-timeout and spurious-response checks, and adds an optional commit-kicked watchdog. Its outputs drive rvfi_order and the simulation-finish decision.

---
 rtl/mem_commit_watchdog.sv | 194 +++++++++++++++++++
 tb/tb_mem_commit_watchdog.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_commit_watchdog.sv
// rtl/mem_commit_watchdog.sv - commit order counter, halt/error/timeout run control and per-port bus sanity monitor
module mem_commit_watchdog #(
   parameter int          NUM_PORTS      = 1,
   parameter int          XLEN           = 32,
   parameter int          ORDER_W        = 64,
   parameter int          TIMEOUT_W      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000000,
   parameter int          KICK_ON_COMMIT = 0,
   parameter int          DRAIN_CYCLES   = 30,
   parameter int          RESP_LIMIT     = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 commit,
   input  logic [XLEN-1:0]      pc_rdata,
   input  logic [XLEN-1:0]      pc_wdata,
   input  logic [15:0]          ext_errcode,
   input  logic [NUM_PORTS-1:0] mem_read,
   input  logic [NUM_PORTS-1:0] mem_write,
   input  logic [NUM_PORTS-1:0] mem_resp,
   output logic [ORDER_W-1:0]   order,
   output logic                 halt,
   output logic                 done,
   output logic [1:0]           cause,
   output logic [15:0]          errcode_q,
   output logic [NUM_PORTS-1:0] rw_err,
   output logic [NUM_PORTS-1:0] resp_err
);

   localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam int WAIT_W  = $clog2(RESP_LIMIT + 1);

   localparam logic [TIMEOUT_W-1:0] WD_RELOAD    = TIMEOUT_W'(TIMEOUT_CYCLES);
   localparam logic [DRAIN_W-1:0]   DRAIN_RELOAD = DRAIN_W'(DRAIN_CYCLES);
   localparam logic [WAIT_W-1:0]    WAIT_MAX     = WAIT_W'(RESP_LIMIT);

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_HALT    = 2'd1;
   localparam logic [1:0] CAUSE_ERRCODE = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ORDER_W-1:0]    order_q, order_d;
   logic [1:0]            cause_q, cause_d;
   logic [15:0]           errcode_d;
   logic [TIMEOUT_W-1:0]  wd_q, wd_d;
   logic [DRAIN_W-1:0]    drain_q, drain_d;
   logic [NUM_PORTS-1:0]  rw_err_q, rw_err_d;
   logic [NUM_PORTS-1:0]  resp_err_q, resp_err_d;
   logic [WAIT_W-1:0]     wait_q [NUM_PORTS];
   logic [WAIT_W-1:0]     wait_d [NUM_PORTS];
   logic                  err_seen;

   // A retiring instruction that jumps to itself is the halt idiom.
   assign halt     = commit && (pc_rdata == pc_wdata);
   assign err_seen = (ext_errcode != 16'd0);

   assign order    = order_q;
   assign cause    = cause_q;
   assign rw_err   = rw_err_q;
   assign resp_err = resp_err_q;

   // Run-control state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: halt beats errcode beats timeout; DRAIN ends when its counter is exhausted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (halt) begin
               state_d = ST_DONE;
            end else if (err_seen) begin
               state_d = ST_DRAIN;
            end else if (wd_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_DONE;
      endcase
   end

   // Outputs decoded from the registered state.
   always_comb begin
      done = (state_q == ST_DONE);
   end

   // Datapath next values: commit order, cause/errcode capture, watchdog and drain counters.
   always_comb begin
      order_d   = order_q;
      cause_d   = cause_q;
      errcode_d = errcode_q;
      wd_d      = wd_q;
      drain_d   = drain_q;
      if (commit && (state_q != ST_DONE)) begin
         order_d = order_q + ORDER_W'(1);
      end
      case (state_q)
         ST_RUN: begin
            if (halt) begin
               cause_d = CAUSE_HALT;
            end else if (err_seen) begin
               cause_d   = CAUSE_ERRCODE;
               errcode_d = ext_errcode;
            end else if (wd_q == '0) begin
               cause_d = CAUSE_TIMEOUT;
            end else if ((KICK_ON_COMMIT != 0) && commit) begin
               wd_d = WD_RELOAD;
            end else begin
               wd_d = wd_q - TIMEOUT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (drain_q != '0) begin
               drain_d = drain_q - DRAIN_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; frozen values in DONE fall out of the next-value logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         order_q   <= '0;
         cause_q   <= CAUSE_NONE;
         errcode_q <= '0;
         wd_q      <= WD_RELOAD;
         drain_q   <= DRAIN_RELOAD;
      end else begin
         order_q   <= order_d;
         cause_q   <= cause_d;
         errcode_q <= errcode_d;
         wd_q      <= wd_d;
         drain_q   <= drain_d;
      end
   end

   // Per-port bus checks, independent of run state: collision, spurious response, response timeout.
   always_comb begin
      rw_err_d   = rw_err_q;
      resp_err_d = resp_err_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         wait_d[i] = '0;
         if ((mem_read[i] || mem_write[i]) && !mem_resp[i]) begin
            wait_d[i] = (wait_q[i] == WAIT_MAX) ? wait_q[i] : wait_q[i] + WAIT_W'(1);
         end
         if (mem_read[i] && mem_write[i]) begin
            rw_err_d[i] = 1'b1;
         end
         if (mem_resp[i] && !mem_read[i] && !mem_write[i]) begin
            resp_err_d[i] = 1'b1;
         end
         if (wait_d[i] == WAIT_MAX) begin
            resp_err_d[i] = 1'b1;
         end
      end
   end

   // Sticky per-port flags and outstanding-request wait counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rw_err_q   <= '0;
         resp_err_q <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            wait_q[i] <= '0;
         end
      end else begin
         rw_err_q   <= rw_err_d;
         resp_err_q <= resp_err_d;
         for (int i = 0; i < NUM_PORTS; i++) begin
            wait_q[i] <= wait_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mem_commit_watchdog.sv
// tb/tb_mem_commit_watchdog.sv - scoreboard bench for mem_commit_watchdog
module tb_mem_commit_watchdog;

   localparam int NP = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          commit = 1'b0;
   logic [31:0]   pc_rdata = '0;
   logic [31:0]   pc_wdata = '0;
   logic [15:0]   ext_errcode = '0;
   logic [NP-1:0] mem_read = '0;
   logic [NP-1:0] mem_write = '0;
   logic [NP-1:0] mem_resp = '0;

   logic [7:0]    order0;
   logic          halt0, done0;
   logic [1:0]    cause0;
   logic [15:0]   err0;
   logic [NP-1:0] rw0, re0;

   logic [5:0]    order1;
   logic          halt1, done1;
   logic [1:0]    cause1;
   logic [15:0]   err1;
   logic [NP-1:0] rw1, re1;

   int total = 0;
   int bad = 0;
   logic [63:0] exp_q[$];
   logic [63:0] e;

   mem_commit_watchdog #(
      .NUM_PORTS(NP), .XLEN(32), .ORDER_W(8), .TIMEOUT_W(8), .TIMEOUT_CYCLES(10),
      .KICK_ON_COMMIT(0), .DRAIN_CYCLES(30), .RESP_LIMIT(4)
   ) dut0 (
      .clk(clk), .rst(rst), .commit(commit), .pc_rdata(pc_rdata), .pc_wdata(pc_wdata),
      .ext_errcode(ext_errcode), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .order(order0), .halt(halt0), .done(done0), .cause(cause0), .errcode_q(err0),
      .rw_err(rw0), .resp_err(re0)
   );

   mem_commit_watchdog #(
      .NUM_PORTS(NP), .XLEN(32), .ORDER_W(6), .TIMEOUT_W(8), .TIMEOUT_CYCLES(10),
      .KICK_ON_COMMIT(1), .DRAIN_CYCLES(30), .RESP_LIMIT(4)
   ) dut1 (
      .clk(clk), .rst(rst), .commit(commit), .pc_rdata(pc_rdata), .pc_wdata(pc_wdata),
      .ext_errcode(ext_errcode), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
      .order(order1), .halt(halt1), .done(done1), .cause(cause1), .errcode_q(err1),
      .rw_err(rw1), .resp_err(re1)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      commit = 1'b0; pc_rdata = '0; pc_wdata = '0; ext_errcode = '0;
      mem_read = '0; mem_write = '0; mem_resp = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      #2;
      for (int k = 0; k < 6; k++) exp_q.push_back(64'd0);
      e = exp_q.pop_front(); total++;
      if (order0 !== e[7:0]) begin bad++; $display("FAIL reset_order: got %0h expected %0h", order0, e[7:0]); end
      e = exp_q.pop_front(); total++;
      if (done0 !== e[0]) begin bad++; $display("FAIL reset_done: got %0h expected %0h", done0, e[0]); end
      e = exp_q.pop_front(); total++;
      if (cause0 !== e[1:0]) begin bad++; $display("FAIL reset_cause: got %0h expected %0h", cause0, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (err0 !== e[15:0]) begin bad++; $display("FAIL reset_errcode: got %0h expected %0h", err0, e[15:0]); end
      e = exp_q.pop_front(); total++;
      if (rw0 !== e[1:0]) begin bad++; $display("FAIL reset_rw_err: got %0h expected %0h", rw0, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (re0 !== e[1:0]) begin bad++; $display("FAIL reset_resp_err: got %0h expected %0h", re0, e[1:0]); end
   endtask

   task automatic test_halt();
      int m_order;
      apply_reset();
      m_order = 0;
      for (int k = 0; k < 3; k++) begin
         commit = 1'b1; pc_rdata = 32'h10 + 32'(k * 4); pc_wdata = pc_rdata + 32'd4;
         exp_q.push_back(64'd0);
         #1;
         e = exp_q.pop_front(); total++;
         if (halt0 !== e[0]) begin bad++; $display("FAIL halt_low: got %0h expected %0h", halt0, e[0]); end
         step();
         m_order++;
      end
      commit = 1'b1; pc_rdata = 32'h60; pc_wdata = 32'h60;
      exp_q.push_back(64'd1);
      exp_q.push_back(64'd0);
      #1;
      e = exp_q.pop_front(); total++;
      if (halt0 !== e[0]) begin bad++; $display("FAIL halt_high: got %0h expected %0h", halt0, e[0]); end
      e = exp_q.pop_front(); total++;
      if (done0 !== e[0]) begin bad++; $display("FAIL halt_done_early: got %0h expected %0h", done0, e[0]); end
      m_order++;
      exp_q.push_back(64'd1);
      exp_q.push_back(64'd1);
      exp_q.push_back(64'(m_order));
      step();
      e = exp_q.pop_front(); total++;
      if (done0 !== e[0]) begin bad++; $display("FAIL halt_done: got %0h expected %0h", done0, e[0]); end
      e = exp_q.pop_front(); total++;
      if (cause0 !== e[1:0]) begin bad++; $display("FAIL halt_cause: got %0h expected %0h", cause0, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (order0 !== e[7:0]) begin bad++; $display("FAIL halt_order: got %0h expected %0h", order0, e[7:0]); end
      exp_q.push_back(64'(m_order));
      pc_rdata = 32'h64; pc_wdata = 32'h68;
      step(); step();
      commit = 1'b0;
      e = exp_q.pop_front(); total++;
      if (order0 !== e[7:0]) begin bad++; $display("FAIL halt_order_frozen: got %0h expected %0h", order0, e[7:0]); end
   endtask

   task automatic test_errcode_drain();
      int n_edge;
      int done_edge;
      int m_order;
      apply_reset();
      n_edge = 3;
      done_edge = n_edge + 30 + 1;
      m_order = 0;
      for (int t = 1; t <= 36; t++) begin
         commit = 1'b1;
         pc_rdata = 32'h100 + 32'(t * 4);
         pc_wdata = (t == 10) ? pc_rdata : pc_rdata + 32'd4;
         ext_errcode = (t == n_edge) ? 16'd5 : 16'd0;
         if (t == n_edge) begin
            exp_q.push_back(64'd0);
            exp_q.push_back(64'd1);
            exp_q.push_back(64'd2);
            exp_q.push_back(64'd5);
         end
         if (t <= done_edge) m_order++;
         step();
         if (t == done_edge - 1) begin
            e = exp_q.pop_front(); total++;
            if (done0 !== e[0]) begin bad++; $display("FAIL drain_done_early: got %0h expected %0h", done0, e[0]); end
         end
         if (t == done_edge) begin
            e = exp_q.pop_front(); total++;
            if (done0 !== e[0]) begin bad++; $display("FAIL drain_done: got %0h expected %0h", done0, e[0]); end
            e = exp_q.pop_front(); total++;
            if (cause0 !== e[1:0]) begin bad++; $display("FAIL drain_cause: got %0h expected %0h", cause0, e[1:0]); end
            e = exp_q.pop_front(); total++;
            if (err0 !== e[15:0]) begin bad++; $display("FAIL drain_errcode: got %0h expected %0h", err0, e[15:0]); end
            exp_q.push_back(64'(m_order));
         end
      end
      idle_inputs();
      e = exp_q.pop_front(); total++;
      if (order0 !== e[7:0]) begin bad++; $display("FAIL drain_order: got %0h expected %0h", order0, e[7:0]); end
   endtask

   task automatic test_same_edge();
      apply_reset();
      commit = 1'b1; pc_rdata = 32'h80; pc_wdata = 32'h80; ext_errcode = 16'd7;
      exp_q.push_back(64'd1);
      exp_q.push_back(64'd1);
      exp_q.push_back(64'd0);
      step();
      idle_inputs();
      e = exp_q.pop_front(); total++;
      if (done0 !== e[0]) begin bad++; $display("FAIL same_edge_done: got %0h expected %0h", done0, e[0]); end
      e = exp_q.pop_front(); total++;
      if (cause0 !== e[1:0]) begin bad++; $display("FAIL same_edge_cause: got %0h expected %0h", cause0, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (err0 !== e[15:0]) begin bad++; $display("FAIL same_edge_errcode: got %0h expected %0h", err0, e[15:0]); end
   endtask

   task automatic test_watchdog();
      apply_reset();
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd1);
      exp_q.push_back(64'd3);
      exp_q.push_back(64'd1);
      for (int t = 1; t <= 11; t++) begin
         step();
         if (t == 10) begin
            e = exp_q.pop_front(); total++;
            if (done0 !== e[0]) begin bad++; $display("FAIL wd_done_early: got %0h expected %0h", done0, e[0]); end
         end
      end
      e = exp_q.pop_front(); total++;
      if (done0 !== e[0]) begin bad++; $display("FAIL wd_done: got %0h expected %0h", done0, e[0]); end
      e = exp_q.pop_front(); total++;
      if (cause0 !== e[1:0]) begin bad++; $display("FAIL wd_cause: got %0h expected %0h", cause0, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (done1 !== e[0]) begin bad++; $display("FAIL wd_kick_dut_done: got %0h expected %0h", done1, e[0]); end
   endtask

   task automatic test_kick();
      int n_commits;
      logic seen_done;
      apply_reset();
      n_commits = 0;
      seen_done = 1'b0;
      for (int t = 1; t <= 1000; t++) begin
         commit = ((t % 5) == 1);
         pc_rdata = 32'h200 + 32'(t * 4);
         pc_wdata = pc_rdata + 32'd8;
         if (commit) n_commits++;
         step();
         if (done1) seen_done = 1'b1;
      end
      idle_inputs();
      exp_q.push_back(64'd0);
      exp_q.push_back(64'(n_commits % 64));
      exp_q.push_back(64'd3);
      e = exp_q.pop_front(); total++;
      if (seen_done !== e[0]) begin bad++; $display("FAIL kick_no_done: got %0h expected %0h", seen_done, e[0]); end
      e = exp_q.pop_front(); total++;
      if (order1 !== e[5:0]) begin bad++; $display("FAIL kick_order_wrap: got %0h expected %0h", order1, e[5:0]); end
      e = exp_q.pop_front(); total++;
      if (cause0 !== e[1:0]) begin bad++; $display("FAIL kick_unkicked_cause: got %0h expected %0h", cause0, e[1:0]); end
   endtask

   task automatic kick_step();
      commit = 1'b1;
      pc_rdata = pc_rdata + 32'd4;
      pc_wdata = pc_rdata + 32'd4;
      step();
   endtask

   task automatic test_bus();
      apply_reset();
      pc_rdata = 32'h400;
      mem_read = 2'b10; mem_write = 2'b10;
      exp_q.push_back(64'h2);
      exp_q.push_back(64'h0);
      kick_step();
      mem_read = '0; mem_write = '0;
      e = exp_q.pop_front(); total++;
      if (rw1 !== e[1:0]) begin bad++; $display("FAIL bus_rw_err: got %0h expected %0h", rw1, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (re1 !== e[1:0]) begin bad++; $display("FAIL bus_resp_clean: got %0h expected %0h", re1, e[1:0]); end
      mem_read = 2'b01;
      exp_q.push_back(64'h0);
      for (int k = 0; k < 3; k++) kick_step();
      mem_read = '0;
      e = exp_q.pop_front(); total++;
      if (re1 !== e[1:0]) begin bad++; $display("FAIL bus_wait3_ok: got %0h expected %0h", re1, e[1:0]); end
      kick_step();
      mem_read = 2'b10;
      kick_step(); kick_step();
      mem_resp = 2'b10;
      exp_q.push_back(64'h0);
      kick_step();
      mem_read = '0; mem_resp = '0;
      e = exp_q.pop_front(); total++;
      if (re1 !== e[1:0]) begin bad++; $display("FAIL bus_resp_in_time: got %0h expected %0h", re1, e[1:0]); end
      kick_step();
      mem_read = 2'b01;
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h1);
      for (int k = 0; k < 3; k++) kick_step();
      e = exp_q.pop_front(); total++;
      if (re1 !== e[1:0]) begin bad++; $display("FAIL bus_wait_pre_limit: got %0h expected %0h", re1, e[1:0]); end
      kick_step();
      mem_read = '0;
      e = exp_q.pop_front(); total++;
      if (re1 !== e[1:0]) begin bad++; $display("FAIL bus_wait_limit: got %0h expected %0h", re1, e[1:0]); end
      mem_resp = 2'b10;
      exp_q.push_back(64'h3);
      exp_q.push_back(64'h3);
      exp_q.push_back(64'h0);
      kick_step();
      idle_inputs();
      e = exp_q.pop_front(); total++;
      if (re1 !== e[1:0]) begin bad++; $display("FAIL bus_spurious: got %0h expected %0h", re1, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (re0 !== e[1:0]) begin bad++; $display("FAIL bus_flags_in_done: got %0h expected %0h", re0, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (done1 !== e[0]) begin bad++; $display("FAIL bus_no_done: got %0h expected %0h", done1, e[0]); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      commit = 1'b1; pc_rdata = 32'h500; pc_wdata = 32'h504; ext_errcode = 16'd9;
      mem_read = 2'b11; mem_write = 2'b11;
      step();
      ext_errcode = '0; mem_read = '0; mem_write = '0;
      for (int k = 0; k < 4; k++) begin
         pc_rdata = pc_rdata + 32'd4; pc_wdata = pc_rdata + 32'd4;
         step();
      end
      exp_q.push_back(64'd2);
      e = exp_q.pop_front(); total++;
      if (cause0 !== e[1:0]) begin bad++; $display("FAIL arst_pre_cause: got %0h expected %0h", cause0, e[1:0]); end
      #2;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 6; k++) exp_q.push_back(64'd0);
      e = exp_q.pop_front(); total++;
      if (order0 !== e[7:0]) begin bad++; $display("FAIL arst_order: got %0h expected %0h", order0, e[7:0]); end
      e = exp_q.pop_front(); total++;
      if (done0 !== e[0]) begin bad++; $display("FAIL arst_done: got %0h expected %0h", done0, e[0]); end
      e = exp_q.pop_front(); total++;
      if (cause0 !== e[1:0]) begin bad++; $display("FAIL arst_cause: got %0h expected %0h", cause0, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (err0 !== e[15:0]) begin bad++; $display("FAIL arst_errcode: got %0h expected %0h", err0, e[15:0]); end
      e = exp_q.pop_front(); total++;
      if (rw0 !== e[1:0]) begin bad++; $display("FAIL arst_rw_err: got %0h expected %0h", rw0, e[1:0]); end
      e = exp_q.pop_front(); total++;
      if (re0 !== e[1:0]) begin bad++; $display("FAIL arst_resp_err: got %0h expected %0h", re0, e[1:0]); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         pc_rdata = pc_rdata + 32'd4; pc_wdata = pc_rdata + 32'd4;
         step();
      end
      commit = 1'b0;
      exp_q.push_back(64'd3);
      exp_q.push_back(64'd0);
      e = exp_q.pop_front(); total++;
      if (order0 !== e[7:0]) begin bad++; $display("FAIL arst_resume_order: got %0h expected %0h", order0, e[7:0]); end
      e = exp_q.pop_front(); total++;
      if (done0 !== e[0]) begin bad++; $display("FAIL arst_resume_done: got %0h expected %0h", done0, e[0]); end
   endtask

   initial begin
      test_reset();
      test_halt();
      test_errcode_drain();
      test_same_edge();
      test_watchdog();
      test_kick();
      test_bus();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
